// File: rtl/ps2_paddle_keys.sv
// PS/2 scan-code-set-2 receiver driving left paddle up/down levels.
// Ports: clk_50MHz, reset (async, low), kb_clk/kb_data in; upl/downl out. Option: PARITY_CHECK_EN.
module ps2_paddle_keys #(
  parameter logic [7:0] UP_CODE     = 8'h1C,
  parameter logic [7:0] DOWN_CODE   = 8'h1A,
  parameter int         TIMEOUT_CYC = 3000
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic kb_clk,
  input  logic kb_data,
  output logic upl,
  output logic downl
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [2:0]    kc_sync;
  logic [1:0]    kd_sync;
  logic          fall;
  logic          bit_in;
  logic [3:0]    bit_cnt;
  logic [8:0]    sr;
  logic [TW-1:0] tmo;
  logic          byte_vld;
  logic [7:0]    byte_q;
  logic          frame_ok;
  logic          brk;
  logic          ext;

  assign fall   = ~kc_sync[1] & kc_sync[2];
  assign bit_in = kd_sync[1];

`ifdef PARITY_CHECK_EN
  // odd parity over d0..d7+parity, and stop bit must be 1
  assign frame_ok = (^sr) & bit_in;
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      kc_sync <= 3'b111;
      kd_sync <= 2'b11;
    end else begin
      kc_sync <= {kc_sync[1:0], kb_clk};
      kd_sync <= {kd_sync[0], kb_data};
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      sr       <= '0;
      tmo      <= '0;
      byte_vld <= 1'b0;
      byte_q   <= '0;
    end else begin
      byte_vld <= 1'b0;
      if (fall) begin
        tmo <= '0;
        unique case (1'b1)
          bit_cnt == 4'd0: begin
            // a 1 here is not a start bit: stay idle
            if (!bit_in) bit_cnt <= 4'd1;
          end
          bit_cnt == 4'd10: begin
            bit_cnt  <= '0;
            byte_q   <= sr[7:0];
            byte_vld <= frame_ok;
          end
          default: begin
            sr      <= {bit_in, sr[8:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        endcase
      end else if (bit_cnt != 4'd0) begin
        if (tmo == TMO_LAST) begin
          bit_cnt <= '0;
          sr      <= '0;
          tmo     <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else begin
        tmo <= '0;
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      upl   <= 1'b0;
      downl <= 1'b0;
      brk   <= 1'b0;
      ext   <= 1'b0;
    end else if (byte_vld) begin
      unique case (1'b1)
        byte_q == 8'hF0: brk <= 1'b1;
        byte_q == 8'hE0: ext <= 1'b1;
        default: begin
          if (!ext) begin
            if (byte_q == UP_CODE)   upl   <= ~brk;
            if (byte_q == DOWN_CODE) downl <= ~brk;
          end
          brk <= 1'b0;
          ext <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_paddle_keys.sv
// Self-checking bench for ps2_paddle_keys.
// Drives PS/2 frames; a key-state model is compared every settled cycle.
module tb_ps2_paddle_keys;

  localparam time HALF = 1000ns;
  localparam time GAP  = 10us;

  logic clk_50MHz = 1'b0;
  logic reset     = 1'b0;
  logic kb_clk    = 1'b1;
  logic kb_data   = 1'b1;
  logic upl, downl;

  int n_tests = 0;
  int n_fail  = 0;

  bit busy = 1'b1;
  bit m_upl = 0, m_downl = 0, m_brk = 0, m_ext = 0;

  ps2_paddle_keys dut (
    .clk_50MHz(clk_50MHz),
    .reset    (reset),
    .kb_clk   (kb_clk),
    .kb_data  (kb_data),
    .upl      (upl),
    .downl    (downl)
  );

  always #10ns clk_50MHz = ~clk_50MHz;

  // key-state model: what a held-key tracker must report after byte b
  task automatic model_byte(input logic [7:0] b, input bit bad);
`ifdef PARITY_CHECK_EN
    if (bad) return;
`endif
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      if (!m_ext && b == 8'h1C) m_upl = !m_brk;
      if (!m_ext && b == 8'h1A) m_downl = !m_brk;
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  always @(negedge clk_50MHz) begin
    if (!busy) begin
      n_tests++;
      if (upl !== m_upl || downl !== m_downl) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t upl=%b downl=%b expected upl=%b downl=%b",
                 $time, upl, downl, m_upl, m_downl);
      end
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad, input int n);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      kb_data = f[i];
      #HALF;
      if (i == 10) busy = 1;
      kb_clk = 1'b0;
      if (i == 10) begin
        repeat (8) @(posedge clk_50MHz);
        #1;
        model_byte(b, bad);
        busy = 0;
      end
      #HALF;
      kb_clk = 1'b1;
    end
    kb_data = 1'b1;
    #GAP;
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  initial begin
    #200ns;
    chk("reset_upl", upl, 1'b0);
    chk("reset_downl", downl, 1'b0);
    @(posedge clk_50MHz);
    #1;
    reset = 1'b1;
    busy  = 0;
    #5us;
    chk("idle_upl", upl, 1'b0);
    chk("idle_downl", downl, 1'b0);

    send(8'h1C);
    chk("make_up_upl", upl, 1'b1);
    chk("make_up_downl", downl, 1'b0);
    send(8'hF0);
    chk("after_f0_upl", upl, 1'b1);
    send(8'h1C);
    chk("break_up_upl", upl, 1'b0);

    send(8'h1A);
    send(8'h1C);
    chk("both_downl", downl, 1'b1);
    chk("both_upl", upl, 1'b1);
    send(8'h1C);
    chk("typematic_upl", upl, 1'b1);
    send(8'hF0);
    send(8'h1A);
    chk("break_down_downl", downl, 1'b0);
    chk("break_down_upl", upl, 1'b1);

    send(8'hE0);
    send(8'h1C);
    chk("ext_make_upl", upl, 1'b1);
    send(8'hE0);
    send(8'hF0);
    send(8'h1C);
    chk("ext_break_upl", upl, 1'b1);
    send(8'h1C);
    chk("after_ext_upl", upl, 1'b1);

    send(8'hF0);
    send(8'h1C);
    chk("rel_upl", upl, 1'b0);
    send_bits(8'h1C, 1'b0, 5);
    #90us;
    send(8'h1C);
    chk("timeout_resync_upl", upl, 1'b1);

    send(8'hF0);
    send(8'h1C);
    chk("pre_parity_upl", upl, 1'b0);
    send_bits(8'h1C, 1'b1, 11);
`ifdef PARITY_CHECK_EN
    chk("bad_parity_upl", upl, 1'b0);
`else
    chk("bad_parity_upl", upl, 1'b1);
`endif

    send(8'h1A);
    send_bits(8'h1C, 1'b0, 6);
    busy  = 1;
    reset = 1'b0;
    m_upl = 0; m_downl = 0; m_brk = 0; m_ext = 0;
    #200ns;
    chk("midreset_upl", upl, 1'b0);
    chk("midreset_downl", downl, 1'b0);
    @(posedge clk_50MHz);
    #1;
    reset = 1'b1;
    busy  = 0;
    #5us;
    send(8'h1C);
    chk("post_reset_upl", upl, 1'b1);
    chk("post_reset_downl", downl, 1'b0);

    #2us;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
